// File: rtl/ps2_pkg.sv
// Shared constants, event payload and FSM encoding for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  // Bytes following the leading E1 of the pause sequence that are swallowed.
  localparam int unsigned PS2_PAUSE_TAIL = 7;
  localparam int unsigned PS2_PAUSE_W    = 3;

  localparam int unsigned PS2_EVT_W        = 10;
  localparam int unsigned PS2_EVT_CODE_LSB = 0;
  localparam int unsigned PS2_EVT_BRK_BIT  = 8;
  localparam int unsigned PS2_EVT_EXT_BIT  = 9;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_REQ    = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_DECODE = 4'b1000
  } ps2_state_e;

  function automatic ps2_evt_t ps2_make_evt(input logic ext, input logic brk,
                                            input logic [7:0] code);
    ps2_evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO holding decoded key events.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock_quarter,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty_c,
  output logic                     drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full_c;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign do_pop  = pop && !empty_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full_c || do_pop);
  assign drop_c  = push && full_c && !do_pop;
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clock_quarter or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Requests bytes from ps2_rx, folds E0/F0/E1 prefixes into key events and queues them.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PREFIX_TIMEOUT = 8
) (
  input  logic       clock_quarter,
  input  logic       reset,
  input  logic       rx_ready,
  input  logic       rx_finish,
  input  logic       rx_faild,
  input  logic [7:0] rx_data,
  output logic       rx_start,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic [7:0] fail_cnt,
  output logic       overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned RUN_W = $clog2(PREFIX_TIMEOUT + 1);

  ps2_state_e             state_q, state_d;
  logic                   faild_q, faild_d;
  logic [7:0]             data_q, data_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [PS2_PAUSE_W-1:0] pause_q, pause_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [7:0]             fail_cnt_q, fail_cnt_d;
  logic                   push_q, push_d;
  ps2_evt_t               push_evt_q, push_evt_d;
  logic                   overflow_q;

  logic [PS2_EVT_W-1:0]   head_c;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty_c;
  logic                   fifo_drop_c;

  // Next-state and decode datapath.
  always_comb begin
    state_d    = state_q;
    faild_d    = faild_q;
    data_d     = data_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    pause_d    = pause_q;
    run_d      = run_q;
    fail_cnt_d = fail_cnt_q;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;

    unique case (state_q)
      ST_IDLE: begin
        // push_q still pending means the count does not yet reflect the last event.
        if (rx_ready && (fifo_count < CNT_W'(DEPTH)) && !push_q) state_d = ST_REQ;
      end
      ST_REQ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rx_finish) begin
          state_d = ST_DECODE;
          faild_d = rx_faild;
          data_d  = rx_data;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (faild_q) begin
          if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          if ((run_q + RUN_W'(1)) == RUN_W'(PREFIX_TIMEOUT)) begin
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            pause_d = '0;
            run_d   = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
          if (pause_q != '0) begin
            pause_d = pause_q - PS2_PAUSE_W'(1);
            if (pause_q == PS2_PAUSE_W'(1)) begin
              push_d     = 1'b1;
              push_evt_d = ps2_make_evt(1'b0, 1'b0, PS2_PFX_PAUSE);
            end
          end else if (data_q == PS2_PFX_PAUSE) begin
            pause_d = PS2_PAUSE_W'(PS2_PAUSE_TAIL);
          end else if (data_q == PS2_PFX_EXT) begin
            ext_d = 1'b1;
          end else if (data_q == PS2_PFX_BRK) begin
            brk_d = 1'b1;
          end else begin
            push_d     = 1'b1;
            push_evt_d = ps2_make_evt(ext_q, brk_q, data_q);
            ext_d      = 1'b0;
            brk_d      = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_quarter or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      faild_q    <= 1'b0;
      data_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      pause_q    <= '0;
      run_q      <= '0;
      fail_cnt_q <= '0;
      push_q     <= 1'b0;
      push_evt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      faild_q    <= faild_d;
      data_q     <= data_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      pause_q    <= pause_d;
      run_q      <= run_d;
      fail_cnt_q <= fail_cnt_d;
      push_q     <= push_d;
      push_evt_q <= push_evt_d;
      overflow_q <= overflow_q | fifo_drop_c;
    end
  end

  ps2_event_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_quarter (clock_quarter),
    .reset         (reset),
    .push          (push_q),
    .push_data     (push_evt_q),
    .pop           (evt_valid && evt_ready),
    .head_c        (head_c),
    .count         (fifo_count),
    .empty_c       (fifo_empty_c),
    .drop_c        (fifo_drop_c)
  );

  assign rx_start  = (state_q == ST_REQ);
  assign evt_valid = !fifo_empty_c;
  assign evt_code  = head_c[PS2_EVT_CODE_LSB +: 8];
  assign evt_brk   = head_c[PS2_EVT_BRK_BIT];
  assign evt_ext   = head_c[PS2_EVT_EXT_BIT];
  assign fail_cnt  = fail_cnt_q;
  assign overflow  = overflow_q;

endmodule
